// File: rtl/instr_fe.sv
// RV32I fetch stage: single-outstanding instruction memory requester
// with a one-entry skid buffer that absorbs a word returned under stall.
module instr_fe #(
  parameter logic [31:0] PC_RESET  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rstn,
  output logic        i_req,
  output logic [31:0] i_addr,
  input  logic        i_ack,
  input  logic [31:0] i_rdata,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic        clk_en,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] new_pc
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_e;

  localparam logic [31:0] ALIGN = 32'hFFFF_FFFC;

  state_e      state_q, state_d;
  logic        i_req_q, i_req_d;
  logic [31:0] i_addr_q, i_addr_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic        clk_en_q, clk_en_d;
  logic [31:0] skid_q, skid_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic        skid_v_q, skid_v_d;
  logic        xfer;
  logic [31:0] addr_inc;

  assign xfer     = i_req_q & i_ack;
  assign addr_inc = i_addr_q + 32'd4;

  always_comb begin
    state_d   = state_q;
    i_req_d   = i_req_q;
    i_addr_d  = i_addr_q;
    instr_d   = instr_q;
    pc_d      = pc_q;
    clk_en_d  = clk_en_q;
    skid_d    = skid_q;
    skid_pc_d = skid_pc_q;
    skid_v_d  = skid_v_q;

    // Redirect beats everything, including a same-cycle ack and stall.
    if (flush) begin
      i_addr_d = new_pc & ALIGN;
      i_req_d  = 1'b1;
      skid_v_d = 1'b0;
      clk_en_d = 1'b0;
      state_d  = RUN;
    end else begin
      unique case (state_q)
        IDLE: begin
          i_req_d  = 1'b1;
          i_addr_d = PC_RESET & ALIGN;
          state_d  = RUN;
        end
        RUN: begin
          unique case (1'b1)
            xfer && !stall: begin
              instr_d  = i_rdata;
              pc_d     = i_addr_q;
              clk_en_d = 1'b1;
              i_addr_d = addr_inc;
            end
            xfer && stall: begin
              skid_d    = i_rdata;
              skid_pc_d = i_addr_q;
              skid_v_d  = 1'b1;
              i_addr_d  = addr_inc;
              i_req_d   = 1'b0;
              state_d   = HOLD;
            end
            !xfer && !stall: begin
              clk_en_d = 1'b0;
            end
            default: begin
            end
          endcase
        end
        HOLD: begin
          if (!stall) begin
            instr_d  = skid_q;
            pc_d     = skid_pc_q;
            clk_en_d = skid_v_q;
            skid_v_d = 1'b0;
            i_req_d  = 1'b1;
            state_d  = RUN;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      i_req_q   <= 1'b0;
      i_addr_q  <= PC_RESET & ALIGN;
      instr_q   <= NOP_INSTR;
      pc_q      <= 32'h0;
      clk_en_q  <= 1'b0;
      skid_q    <= 32'h0;
      skid_pc_q <= 32'h0;
      skid_v_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      i_req_q   <= i_req_d;
      i_addr_q  <= i_addr_d;
      instr_q   <= instr_d;
      pc_q      <= pc_d;
      clk_en_q  <= clk_en_d;
      skid_q    <= skid_d;
      skid_pc_q <= skid_pc_d;
      skid_v_q  <= skid_v_d;
    end
  end

  assign i_req  = i_req_q;
  assign i_addr = i_addr_q;
  assign instr  = instr_q;
  assign pc     = pc_q;
  assign clk_en = clk_en_q;

endmodule

// File: doc/instr_fe.md
Name: instr_fe

Overview:
- RV32I fetch stage: producer side of the decode-stage pipeline handshake (instr / PC / clk_en / stall / flush).
- Generates word-aligned fetch addresses and runs a single-outstanding request/ack protocol to instruction memory.
- Registers each fetched word with its PC for the decode stage.
- Absorbs one in-flight word in a skid buffer while the pipeline is stalled; restarts at a new PC on redirect (branch, jump, trap).

Parameters:
- PC_RESET, 32'h0000_0000, first fetch address after reset (bits [1:0] must be 0).
- NOP_INSTR, 32'h0000_0013, value driven on instr at reset (addi x0,x0,0).

Ports:
- clk  input  1  clock
- rstn  input  1  asynchronous, active-low reset
- i_req  output  1  instruction memory request, registered
- i_addr  output  32  instruction memory word address, registered, bits [1:0] always 0
- i_ack  input  1  memory response valid; meaningful only while i_req=1
- i_rdata  input  32  instruction word, valid with i_ack
- instr  output  32  fetched instruction to decode
- pc  output  32  address of instr
- clk_en  output  1  instr/pc valid; clock-enable for decode
- stall  input  1  pipeline stall from decode
- flush  input  1  redirect request from later stages
- new_pc  input  32  redirect target, sampled when flush=1

Behaviour:
- Reset values:
  - i_req=0, i_addr=PC_RESET, instr=NOP_INSTR, pc=0, clk_en=0.
  - Skid buffer valid buf_v=0; state=IDLE.
- Transfer = cycle with i_req=1 and i_ack=1. Memory may ack in the same cycle as the request (zero wait) or after N wait cycles. i_addr is held stable until transfer or redirect.
- States:
  - IDLE: entered only from reset. Next cycle: i_req<=1, i_addr=PC_RESET -> RUN.
  - RUN (i_req=1):
    - transfer and !stall: instr<=i_rdata, pc<=i_addr, clk_en<=1, i_addr<=i_addr+4 (mod 2^32, wraps to 0), stay RUN. Throughput is 1 instr/cycle with a zero-wait memory.
    - transfer and stall: buf<=i_rdata, buf_pc<=i_addr, buf_v<=1, i_addr<=i_addr+4, i_req<=0 -> HOLD. instr/pc/clk_en hold.
    - no transfer and !stall: clk_en<=0 (bubble); instr/pc may hold their old values.
    - no transfer and stall: all outputs hold.
  - HOLD (i_req=0, buf_v=1):
    - stall: everything holds.
    - !stall: instr<=buf, pc<=buf_pc, clk_en<=1, buf_v<=0, i_req<=1 -> RUN. Next request goes out the cycle after release, so fetch loses one cycle per stall release.
- Redirect (flush=1) has priority over everything, in any state, stalled or not:
  - i_addr<=new_pc with bits [1:0] forced to 0; i_req<=1; buf_v<=0; clk_en<=0 -> RUN.
  - An i_ack in the flush cycle is discarded: its data never reaches instr.
  - First word from the new target appears on instr no earlier than 2 cycles after flush.
- Simultaneous flush+stall: redirect still taken. clk_en=0 ensures decode captures nothing stale.
- Consecutive flushes: the last one wins; each restarts the request at its own target.
- The decode stage samples only when clk_en=1 and stall=0. Fetch must never change instr/pc while clk_en=1 and stall=1.
- i_ack while i_req=0 is ignored.
- Reset mid-operation: all state returns immediately to reset values. An outstanding request is abandoned; any later i_ack is ignored because i_req=0.

Test Plan:
- Reset release, zero-wait memory returning word=addr ^ 32'hA5A5_0000:
  - i_addr sequence 0,4,8,12.
  - clk_en=1 from the 3rd cycle after release.
  - pc=0,4,8 back-to-back with matching instr.
- Memory with 2 wait cycles per access:
  - i_addr stable for 3 cycles each.
  - clk_en pulses 1 for one cycle per word, 0 in between.
  - pc increments by 4 per pulse.
- Stall asserted 3 cycles while an ack arrives (word 0x0000_0093 at 0x10):
  - instr/pc hold their prior values; i_req drops.
  - On release: instr=0x0000_0093, pc=0x10, clk_en=1, i_addr=0x14 with i_req=1.
- flush with new_pc=0x0000_0203 coincident with i_ack:
  - acked word dropped; clk_en=0.
  - Next cycle i_addr=0x200, i_req=1; next pc seen by decode=0x200.
- flush during HOLD with stall held high:
  - buffered word discarded; i_addr=new_pc.
  - After stall drops, the first clk_en=1 carries pc=new_pc.
- rstn pulsed low mid-stream:
  - i_req=0, clk_en=0, instr=0x0000_0013 asynchronously.
  - After release, fetch restarts at PC_RESET.
  - PC wrap: redirect to 0xFFFF_FFFC gives next i_addr=0x0.
